fft_cplx_delay_line: RTL and testbench

Parametrised complex delay line for the SDF FFT datapath. It delays a complex sample stream by a runtime-selectable number of enabled clock cycles, from 1 to MAX_DELAY, so that one instance can serve every butterfly stage. Storage is a circular buffer rather than a register chain. An output-valid flag tracks buffer priming after reset or after a length change, and an error flag reports illegal lengths.

---
 rtl/fft_cplx_delay_line.sv | 130 +++++++++++++
 tb/tb_fft_cplx_delay_line.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fft_cplx_delay_line.sv
// Complex delay line for the SDF FFT: runtime length 1..MAX_DELAY on a circular RAM.
// Build option FFT_DELAY_ZERO_FILL_EN forces x_out to zero while out_valid is low.
module fft_cplx_delay_line #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_DELAY = 64,
  parameter int unsigned LEN_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LEN_W-1:0]  delay_len,
  input  logic [DATA_W-1:0] x_in_re,
  input  logic [DATA_W-1:0] x_in_im,
  output logic [DATA_W-1:0] x_out_re,
  output logic [DATA_W-1:0] x_out_im,
  output logic              out_valid,
  output logic              len_err
);

  localparam int unsigned PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned SMP_W = 2 * DATA_W;

  logic [SMP_W-1:0] mem [MAX_DELAY];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fill_cnt;
  logic [LEN_W-1:0] fill_nxt;
  logic [LEN_W-1:0] l_eff;
  logic [LEN_W-1:0] lag;
  logic [LEN_W-1:0] wr_ext;
  logic [LEN_W-1:0] rd_ext;
  logic             len_chg;
  logic             valid_nxt;
  logic             err_nxt;
  logic [SMP_W-1:0] smp_in;
  logic [SMP_W-1:0] smp_rd;
  logic [SMP_W-1:0] smp_nxt;

  // Effective length: 0 behaves as 1, oversize lengths clamp to the buffer depth
  always_comb begin
    l_eff   = delay_len;
    err_nxt = 1'b0;
    if (delay_len == '0) begin
      l_eff   = LEN_W'(1);
      err_nxt = 1'b1;
    end else if (delay_len > LEN_W'(MAX_DELAY)) begin
      l_eff   = LEN_W'(MAX_DELAY);
      err_nxt = 1'b1;
    end
  end

  // Read address = wr_ptr - (L_eff-1) mod MAX_DELAY; modular overflow of the
  // intermediate sum is harmless because the final result is below MAX_DELAY
  always_comb begin
    lag    = l_eff - LEN_W'(1);
    wr_ext = LEN_W'(wr_ptr);
    if (wr_ext >= lag) begin
      rd_ext = wr_ext - lag;
    end else begin
      rd_ext = wr_ext + LEN_W'(MAX_DELAY) - lag;
    end
    rd_ptr  = PTR_W'(rd_ext);
    smp_in  = {x_in_re, x_in_im};
    smp_rd  = mem[rd_ptr];
    smp_nxt = (l_eff == LEN_W'(1)) ? smp_in : smp_rd;
  end

  // Pointer advance and priming control; a length change restarts priming
  always_comb begin
    len_chg    = (delay_len != len_q);
    wr_ptr_nxt = wr_ptr;
    fill_nxt   = fill_cnt;
    valid_nxt  = out_valid;
    if (enable) begin
      wr_ptr_nxt = (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (len_chg) begin
      fill_nxt  = '0;
      valid_nxt = 1'b0;
    end else if (enable) begin
      if (fill_cnt < l_eff) begin
        fill_nxt = fill_cnt + LEN_W'(1);
      end
      if (fill_nxt >= l_eff) begin
        valid_nxt = 1'b1;
      end
    end
  end

  // Sample storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (enable) begin
      mem[wr_ptr] <= smp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
      x_out_re  <= '0;
      x_out_im  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      fill_cnt  <= fill_nxt;
      len_q     <= delay_len;
      out_valid <= valid_nxt;
      len_err   <= err_nxt;
`ifdef FFT_DELAY_ZERO_FILL_EN
      if (!valid_nxt) begin
        x_out_re <= '0;
        x_out_im <= '0;
      end else if (enable) begin
        {x_out_re, x_out_im} <= smp_nxt;
      end
`else
      if (enable) begin
        {x_out_re, x_out_im} <= smp_nxt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft_cplx_delay_line.sv
// Scoreboard bench for fft_cplx_delay_line: driver queues samples, monitor pops on valid enabled edges.
module tb_fft_cplx_delay_line;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_DELAY = 64;
  localparam int unsigned LEN_W     = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [LEN_W-1:0]  delay_len;
  logic [DATA_W-1:0] x_in_re;
  logic [DATA_W-1:0] x_in_im;
  logic [DATA_W-1:0] x_out_re;
  logic [DATA_W-1:0] x_out_im;
  logic              out_valid;
  logic              len_err;

  fft_cplx_delay_line #(
    .DATA_W   (DATA_W),
    .MAX_DELAY(MAX_DELAY),
    .LEN_W    (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .delay_len(delay_len),
    .x_in_re  (x_in_re),
    .x_in_im  (x_in_im),
    .x_out_re (x_out_re),
    .x_out_im (x_out_im),
    .out_valid(out_valid),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          prime;
  int          cur_leff;
  int          prev_len;
  bit          chg;

  function automatic int leff(input int l);
    if (l == 0) return 1;
    if (l > int'(MAX_DELAY)) return int'(MAX_DELAY);
    return l;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected response goes into the scoreboard
  task automatic step(input bit en, input int len, input int re, input int im);
    @(negedge clk);
    enable    = en;
    delay_len = LEN_W'(len);
    x_in_re   = DATA_W'(re);
    x_in_im   = DATA_W'(im);
    cur_leff  = leff(len);
    chg       = (len != prev_len);
    prev_len  = len;
    if (chg) begin
      exp_q.delete();
      prime = 0;
    end else if (en) begin
      exp_q.push_back({DATA_W'(re), DATA_W'(im)});
      if (prime < cur_leff) prime++;
    end
  endtask

  // Release reset; the following edge sees delay_len != 0 and counts as a length change
  task automatic release_rst();
    @(negedge clk);
    rst      = 1'b0;
    enable   = 1'b0;
    chg      = 1'b1;
    prime    = 0;
    exp_q.delete();
    prev_len = int'(delay_len);
    cur_leff = leff(prev_len);
  endtask

  logic              s_en;
  logic              s_rst;
  logic              s_chg;
  int                s_len;
  logic [DATA_W-1:0] prev_re;
  logic [DATA_W-1:0] prev_im;
  logic [31:0]       e;

  // Monitor: check priming flag, len_err, data on valid enabled edges, hold on idle edges
  always begin
    @(posedge clk);
    s_en  = enable;
    s_rst = rst;
    s_chg = chg;
    s_len = int'(delay_len);
    #1;
    if (!s_rst && !rst) begin
      cmp("out_valid", 32'(out_valid), 32'(prime >= cur_leff));
      cmp("len_err", 32'(len_err), 32'((s_len == 0) || (s_len > int'(MAX_DELAY))));
      if (s_en && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty: got %h%h with no expected sample at %0t",
                   x_out_re, x_out_im, $time);
        end else begin
          e = exp_q.pop_front();
          cmp("x_out", {x_out_re, x_out_im}, e);
        end
      end else if (!s_en && !s_chg) begin
        cmp("hold_x_out", {x_out_re, x_out_im}, {prev_re, prev_im});
      end
`ifdef FFT_DELAY_ZERO_FILL_EN
      if (!out_valid) cmp("zero_fill", {x_out_re, x_out_im}, 32'h0);
`endif
    end
    prev_re = x_out_re;
    prev_im = x_out_im;
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    delay_len = LEN_W'(30);
    x_in_re   = '0;
    x_in_im   = '0;
    prime     = 0;
    cur_leff  = 30;
    prev_len  = 30;
    chg       = 1'b0;
    #12;
    cmp("rst_x_out_re", 32'(x_out_re), 32'h0);
    cmp("rst_x_out_im", 32'(x_out_im), 32'h0);
    cmp("rst_out_valid", 32'(out_valid), 32'h0);
    cmp("rst_len_err", 32'(len_err), 32'h0);
    release_rst();

    // Basic impulse through a 30-deep delay
    step(1'b1, 30, 2, 1);
    repeat (40) step(1'b1, 30, 0, 0);

    // Shortest delay: bypass path
    for (int i = 0; i < 20; i++) step(1'b1, 1, i, i + 100);

    // Full depth across several pointer wraps
    for (int i = 0; i < 232; i++) step(1'b1, 64, i + 1000, 5000 - i);

    // Enable gating at length 4
    for (int i = 0; i < 60; i++) step(((i * 13) % 5) < 3, 4, 2000 + i, i);

    // Mid-stream length change 8 -> 3
    for (int i = 0; i < 30; i++) step(1'b1, 8, 3000 + i, 7 * i);
    for (int i = 0; i < 20; i++) step(1'b1, 3, 3100 + i, 9 * i);

    // Illegal lengths: 0 acts as 1, 65 acts as 64
    for (int i = 0; i < 10; i++) step(1'b1, 0, 4000 + i, i);
    for (int i = 0; i < 80; i++) step(1'b1, 65, 4100 + i, 300 - i);

    // Asynchronous reset between edges, then re-prime
    for (int i = 0; i < 20; i++) step(1'b1, 5, 5000 + i, i);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("async_rst_x_out", {x_out_re, x_out_im}, 32'h0);
    cmp("async_rst_out_valid", 32'(out_valid), 32'h0);
    exp_q.delete();
    prime = 0;
    @(negedge clk);
    release_rst();
    for (int i = 0; i < 20; i++) step(1'b1, 5, 6000 + i, 40 + i);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
